// File: rtl/song_pkg.sv
//------------------------------------------------------------------------------
// song_pkg
//   Shared types and constants for the song player: the sequencer state
//   encoding, ROM field widths and the end-of-song marker.
//   Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package song_pkg;

  localparam int NOTE_W = 4;
  localparam int DUR_W  = 16;
  localparam int SONG_W = 4;

  // A ROM entry with this duration terminates the song.
  localparam logic [DUR_W-1:0] END_DUR = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PLAY  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } player_state_t;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
//------------------------------------------------------------------------------
// tick_prescaler
//   Free-running divider that produces a one-cycle tick every TICK_DIV
//   enabled clocks. Holding en low freezes the count in place so a paused
//   note resumes from the exact same phase.
//   Ports:
//     clk   - system clock
//     rst_n - asynchronous active-low reset
//     clr   - synchronous clear back to count 0
//     en    - count enable
//     tick  - high on the enabled cycle where the count wraps
//   Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tick_prescaler #(
  parameter int TICK_DIV = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && !clr && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/song_player.sv
//------------------------------------------------------------------------------
// song_player
//   Walks the song ROM for one selected song, holding each note for its
//   stored duration (in prescaler ticks) and inserting a silent gap after
//   every note so that repeated notes remain distinguishable.
//   Ports:
//     clk, rst_n          - clock, asynchronous active-low reset
//     start, stop, pause  - playback control (levels)
//     song_sel            - song index, latched on start
//     rom_address/rom_song- ROM lookup address and latched song index
//     rom_note/rom_duration- combinational ROM read data
//     note_out/note_valid - current note to the tone generator
//     playing             - sequencer busy (FETCH, PLAY, GAP)
//     done                - one-cycle pulse on natural end of song
//   Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module song_player
  import song_pkg::*;
#(
  parameter int TICK_DIV  = 10000,
  parameter int GAP_TICKS = 200,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [SONG_W-1:0] song_sel,
  output logic [ADDR_W-1:0] rom_address,
  output logic [SONG_W-1:0] rom_song,
  input  logic [NOTE_W-1:0] rom_note,
  input  logic [DUR_W-1:0]  rom_duration,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              playing,
  output logic              done
);

  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(GAP_TICKS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

  player_state_t     state;
  logic [DUR_W-1:0]  dur_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic presc_clr;
  logic presc_en;
  logic tick;
  logic note_end;
  logic gap_end;
  logic advance;

  // Prescaler restarts with every fetched note so each note begins on a
  // fresh unit boundary; pause freezes it only while time is being counted.
  assign presc_clr = (state == FETCH);
  assign presc_en  = ((state == PLAY) || (state == GAP)) && !pause;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (tick)
  );

  // Exits are taken on the tick that would bring a counter from 1 to 0.
  assign note_end = (state == PLAY) && tick && (dur_cnt == DUR_ONE);
  assign gap_end  = (state == GAP)  && tick && (gap_cnt == GAP_ONE);
  assign advance  = (note_end && (GAP_TICKS == 0)) || gap_end;

  assign playing    = (state == FETCH) || (state == PLAY) || (state == GAP);
  assign note_valid = (state == PLAY) && (note_out != '0) && !pause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rom_address <= '0;
      rom_song    <= '0;
      note_out    <= '0;
      dur_cnt     <= '0;
      gap_cnt     <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && (state != IDLE)) begin
        // Abort: silent return to idle, no completion pulse.
        state       <= IDLE;
        rom_address <= '0;
        rom_song    <= '0;
        note_out    <= '0;
        dur_cnt     <= '0;
        gap_cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              rom_song    <= song_sel;
              rom_address <= '0;
              state       <= FETCH;
            end
          end

          FETCH: begin
            if (rom_duration == END_DUR) begin
              note_out <= '0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              dur_cnt  <= rom_duration;
              note_out <= rom_note;
              state    <= PLAY;
            end
          end

          PLAY: begin
            if (tick) begin
              dur_cnt <= dur_cnt - 1'b1;
            end
            if (note_end && (GAP_TICKS > 0)) begin
              gap_cnt <= GAP_INIT;
              state   <= GAP;
            end
          end

          GAP: begin
            if (tick) begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end

          DONE: begin
            rom_address <= '0;
            rom_song    <= '0;
            state       <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase

        // Step to the next ROM entry; the last address ends the song
        // instead of wrapping back to entry 0.
        if (advance) begin
          if (rom_address == LAST_ADDR) begin
            note_out <= '0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            rom_address <= rom_address + 1'b1;
            state       <= FETCH;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_song_player.sv
//------------------------------------------------------------------------------
// tb_song_player
//   Directed bench for song_player with TICK_DIV=4, GAP_TICKS=1, ADDR_W=5.
//   Expected note runs (note, valid length) are queued when a song is started
//   and compared by a negedge monitor whenever note_valid drops.
//   Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_song_player;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        pause;
  logic [3:0]  song_sel;
  logic [4:0]  rom_address;
  logic [3:0]  rom_song;
  logic [3:0]  rom_note;
  logic [15:0] rom_duration;
  logic [3:0]  note_out;
  logic        note_valid;
  logic        playing;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] note;
    int         len;
  } run_t;

  run_t sb[$];

  song_player #(
    .TICK_DIV  (4),
    .GAP_TICKS (1),
    .ADDR_W    (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .song_sel     (song_sel),
    .rom_address  (rom_address),
    .rom_song     (rom_song),
    .rom_note     (rom_note),
    .rom_duration (rom_duration),
    .note_out     (note_out),
    .note_valid   (note_valid),
    .playing      (playing),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROM: 2 = {(1,2),(5,3),end}, 3 = {(0,3),(4,1),end}, 7 = 32 x (3,1).
  always_comb begin
    rom_note     = 4'd0;
    rom_duration = 16'd0;
    case (rom_song)
      4'd2: begin
        if (rom_address == 5'd0) begin rom_note = 4'd1; rom_duration = 16'd2; end
        if (rom_address == 5'd1) begin rom_note = 4'd5; rom_duration = 16'd3; end
      end
      4'd3: begin
        if (rom_address == 5'd0) begin rom_note = 4'd0; rom_duration = 16'd3; end
        if (rom_address == 5'd1) begin rom_note = 4'd4; rom_duration = 16'd1; end
      end
      4'd7: begin
        rom_note     = 4'd3;
        rom_duration = 16'd1;
      end
      default: ;
    endcase
  end

  // Monitor: note runs against the scoreboard, done pulse bookkeeping.
  logic       prev_valid = 1'b0;
  logic [3:0] run_note   = 4'd0;
  int         run_len    = 0;
  int         done_cnt   = 0;
  int         done_run   = 0;
  int         done_max   = 0;
  int         done_addr  = 0;
  int         done_play  = 0;

  always @(negedge clk) begin
    if (prev_valid && (!note_valid || note_out != run_note)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL run_unexpected: observed note=%0d len=%0d expected none", run_note, run_len);
      end else begin
        run_t e;
        e = sb.pop_front();
        assert (run_note === e.note && run_len === e.len) else begin
          errors++;
          $error("FAIL run: observed note=%0d len=%0d expected note=%0d len=%0d",
                 run_note, run_len, e.note, e.len);
        end
      end
    end
    if (note_valid) begin
      if (prev_valid && note_out == run_note) run_len++;
      else begin
        run_note = note_out;
        run_len  = 1;
      end
    end
    prev_valid = note_valid;

    if (done) begin
      done_run++;
      if (done_run == 1) begin
        done_cnt++;
        done_addr = int'(rom_address);
      end
      if (done_run > done_max) done_max = done_run;
      if (playing) done_play++;
    end else begin
      done_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [3:0] n, input int len);
    run_t e;
    e.note = n;
    e.len  = len;
    sb.push_back(e);
  endtask

  task automatic start_song(input logic [3:0] sel);
    step();
    song_sel = sel;
    start    = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    check(tag, done_cnt - d0, 1);
    step();
  endtask

  initial begin
    int n;
    int bad;
    int span;
    int d_before;

    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    pause    = 1'b0;
    song_sel = 4'd0;
    #12;
    check("reset_address", rom_address, 0);
    check("reset_song", rom_song, 0);
    check("reset_note", note_out, 0);
    check("reset_valid", note_valid, 0);
    check("reset_playing", playing, 0);
    check("reset_done", done, 0);
    step();
    rst_n = 1'b1;
    step();

    // Basic song: note 1 for 8 cycles, note 5 for 12 cycles, then done.
    push_run(4'd1, 8);
    push_run(4'd5, 12);
    start_song(4'd2);
    check("start_playing", playing, 1);
    check("start_song", rom_song, 2);
    check("start_address", rom_address, 0);
    song_sel = 4'd9;
    wait_done(200, "song2_done");
    check("song2_done_addr", done_addr, 2);
    check("song2_done_width", done_max, 1);
    check("song2_done_not_playing", done_play, 0);
    check("song2_idle", playing, 0);
    check("song2_queue_empty", sb.size(), 0);

    // Gap length: 4 GAP cycles plus the 1-cycle FETCH between the notes.
    push_run(4'd1, 8);
    push_run(4'd5, 12);
    start_song(4'd2);
    n = 0;
    while (!note_valid && n < 50) begin step(); n++; end
    n = 0;
    while (note_valid && n < 50) begin step(); n++; end
    n = 0;
    while (!note_valid && n < 50) begin step(); n++; end
    check("gap_plus_fetch_len", n, 5);
    check("song_sel_ignored", rom_song, 2);
    wait_done(200, "gap_done");

    // Rest entry: 12 silent cycles while playing, then note 4 for 4 cycles.
    push_run(4'd4, 4);
    start_song(4'd3);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!(playing && !note_valid)) bad++;
    end
    check("rest_silent_cycles_bad", bad, 0);
    wait_done(200, "rest_done");
    check("rest_queue_empty", sb.size(), 0);

    // Pause for 10 cycles, 3 cycles into note 1: note spans 18 cycles.
    push_run(4'd1, 3);
    push_run(4'd1, 5);
    push_run(4'd5, 12);
    start_song(4'd2);
    n = 0;
    while (!note_valid && n < 50) begin step(); n++; end
    step();
    step();
    step();
    pause = 1'b1;
    #1;
    check("pause_valid_low", note_valid, 0);
    check("pause_playing", playing, 1);
    repeat (10) @(posedge clk);
    #1;
    pause = 1'b0;
    span = 13;
    n = 0;
    #1;
    while (note_valid && n < 50) begin
      span++;
      n++;
      step();
    end
    check("pause_note_span", span, 18);
    wait_done(200, "pause_done");
    check("pause_queue_empty", sb.size(), 0);

    // Stop mid-note 5 with start held: immediate idle, no done.
    push_run(4'd1, 8);
    push_run(4'd5, 5);
    d_before = done_cnt;
    start_song(4'd2);
    n = 0;
    while (!(note_valid && note_out == 4'd5) && n < 100) begin step(); n++; end
    step();
    step();
    step();
    step();
    stop  = 1'b1;
    start = 1'b1;
    step();
    check("stop_playing", playing, 0);
    check("stop_note", note_out, 0);
    check("stop_address", rom_address, 0);
    check("stop_valid", note_valid, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (playing) bad++;
    end
    check("stop_start_blocked", bad, 0);
    stop = 1'b0;
    step();
    check("restart_after_stop", playing, 1);
    start = 1'b0;
    stop  = 1'b1;
    step();
    stop = 1'b0;
    step();
    check("stop_no_done", done_cnt - d_before, 0);
    check("stop_queue_empty", sb.size(), 0);

    // Full ROM: 32 single-unit notes, ends at address 31 without wrapping.
    for (int i = 0; i < 32; i++) push_run(4'd3, 4);
    start_song(4'd7);
    wait_done(600, "full_done");
    check("full_done_addr", done_addr, 31);
    check("full_queue_empty", sb.size(), 0);
    check("full_idle", playing, 0);

    // Asynchronous reset in the gap after note 1.
    push_run(4'd1, 8);
    d_before = done_cnt;
    start_song(4'd2);
    n = 0;
    while (!note_valid && n < 50) begin step(); n++; end
    n = 0;
    while (note_valid && n < 50) begin step(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_playing", playing, 0);
    check("areset_song", rom_song, 0);
    check("areset_address", rom_address, 0);
    check("areset_note", note_out, 0);
    check("areset_valid", note_valid, 0);
    check("areset_done", done, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("areset_no_done", done_cnt - d_before, 0);
    check("areset_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/song_player.md
Name: song_player

Overview:
- Sequencer that reads the song ROM. It walks the ROM address space for one selected song and holds each note for its stored duration.
- Presents the current note to the tone generator and inserts a short silent gap between notes, so repeated notes stay audible as separate notes.
- Sits between the mode/keypad control logic (start/stop/pause, song select) and the buzzer tone generator. The ROM is combinational and read-only.

Parameters:
- TICK_DIV, 10000, clk cycles per duration unit; must be at least 2.
- GAP_TICKS, 200, silent duration units inserted after each note; 0 disables the gap.
- ADDR_W, 5, ROM address width; the maximum song length is 2**ADDR_W entries.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start  in  1  level; sampled only in IDLE
- stop  in  1  level; aborts playback from any state
- pause  in  1  level; freezes timing while high
- song_sel  in  4  song index, latched on start
- rom_address  out  ADDR_W  ROM address
- rom_song  out  4  latched song index driven to the ROM
- rom_note  in  4  ROM note; 0 = rest
- rom_duration  in  16  ROM duration in units; 0 = end of song
- note_out  out  4  current note
- note_valid  out  1  high while a non-rest note sounds and playback is not paused
- playing  out  1  high in FETCH, PLAY and GAP
- done  out  1  one-cycle pulse on natural end of song

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: all outputs are 0, state = IDLE, and prescaler and counters are 0.
- States are IDLE, FETCH, PLAY, GAP, DONE.
- IDLE → FETCH when start=1 and stop=0. On that edge: song_sel is latched into rom_song and rom_address is set to 0.
- FETCH lasts exactly 1 cycle. It samples rom_note and rom_duration into registers.
  - If rom_duration == 0: go to DONE.
  - Otherwise: go to PLAY, load dur_cnt = rom_duration, clear the prescaler and register note_out = rom_note.
- PLAY: the prescaler counts 0 .. TICK_DIV-1. Each wrap is one tick and decrements dur_cnt.
  - When a tick occurs with dur_cnt == 1, leave PLAY.
  - If GAP_TICKS > 0, go to GAP with gap_cnt = GAP_TICKS.
  - Otherwise advance the address (see below).
  - A note therefore lasts exactly duration × TICK_DIV unpaused cycles.
- GAP: note_valid = 0 and note_out holds its value. gap_cnt decrements per tick, and the block advances when a tick occurs with gap_cnt == 1.
- Advance:
  - If rom_address == 2**ADDR_W-1, go to DONE with no wrap.
  - Otherwise rom_address increments by 1 and the state goes to FETCH.
- DONE: done = 1 for exactly that one cycle, with playing = 0. Next state is IDLE. note_out is cleared on entry to DONE.
- note_valid = (state == PLAY) && note_out != 0 && !pause. A rest (note 0) is still timed normally.
- pause=1 in PLAY or GAP holds the prescaler and all counters. Releasing pause resumes the count from the exact same prescaler value. pause has no effect in IDLE, FETCH or DONE.
- stop=1 in any non-IDLE state: next state is IDLE, all outputs are cleared and done is not pulsed.
  - stop wins over start in the same cycle.
  - stop in IDLE has no effect.
- start while not in IDLE is ignored. song_sel changes after latching are ignored until the next start.
- Reset asserted mid-song: immediate return to reset values with no done pulse.
- Width rules:
  - The prescaler width is clog2(TICK_DIV).
  - dur_cnt is 16 bits and never underflows (the exit is taken at 1).
  - gap_cnt width is clog2(GAP_TICKS+1).

Decomposition:
- Package song_pkg holds the state enum player_state_t, NOTE_W=4, DUR_W=16, SONG_W=4 and the end-of-song marker constant END_DUR=0.
- One sub-module, tick_prescaler (parameter TICK_DIV; ports clk, rst_n, clr, en, tick). The parent drives clr on FETCH and en = !pause in PLAY/GAP.

Test Plan:
- Test parameters are TICK_DIV=4 and GAP_TICKS=1. The bench ROM for song 2 is {(1,2),(5,3),(0,0)}.
- Start with song_sel=2. Required response:
  - rom_song=2 and rom_address=0 on the next edge.
  - note_out=1 with note_valid=1 for exactly 8 cycles.
  - note_valid=0 for a 4-cycle gap.
  - note_out=5 with note_valid=1 for 12 cycles, then a 4-cycle gap.
  - done pulses for exactly 1 cycle with rom_address=2, then back to IDLE.
- Rest entry: bench ROM {(0,3),(4,1),(0,0)}. Required: note_valid stays 0 for 12 cycles while playing=1, then note 4 is valid for 4 cycles.
- Pause: assert pause for 10 cycles, 3 cycles into note 1. Required: note_valid=0 during pause and the note ends 10 cycles later than the no-pause case, so the total is 18 cycles.
- Stop: assert stop mid-note 5, with start also held high. Required: next cycle IDLE, playing=0, note_out=0, rom_address=0, done never pulses and start is not re-accepted until stop falls.
- Full ROM: 32 entries, all duration 1 and no end marker. Required: rom_address reaches 31, then DONE with no wrap to 0.
- Reset: drive rst_n=0 asynchronously mid-gap. Required: all outputs are 0 immediately, before the next clk edge.
